// File: rtl/slot_pkg.sv
// Shared types and default sizes for the slot machine game logic.
//   slot_state_e : sequencer states (idle, reels spinning, one-cycle result judgement)
//   reel_pos_t   : one reel position at the default width
//   credit_t     : credit balance at the default width
package slot_pkg;

  localparam int unsigned DefNumReels = 3;
  localparam int unsigned DefSymbols  = 8;
  localparam int unsigned DefSymW     = 3;
  localparam int unsigned DefCreditW  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StSpin,
    StResult
  } slot_state_e;

  typedef logic [DefSymW-1:0]    reel_pos_t;
  typedef logic [DefCreditW-1:0] credit_t;

endpackage

// File: rtl/spin_tick_gen.sv
// Free-running prescaler that emits a one-cycle tick every STEP_CYCLES clocks.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   clr_i  : synchronous clear; holds the count at zero and suppresses the tick
//   tick_o : high for one cycle when the count sits at STEP_CYCLES-1
module spin_tick_gen #(
  parameter int unsigned STEP_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(STEP_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (clr_i || (cnt_q == LastCnt)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = ~clr_i & (cnt_q == LastCnt);

endmodule

// File: rtl/slot_spin_controller.sv
// Slot machine game sequencer: spins all reels on start, stops them in order
// (reel 0 first) on stop requests, judges the result and keeps the credit balance.
//   clk, rst        : clock, synchronous active-high reset
//   start_pulse     : one-cycle start request (costs one credit)
//   stop_pulse      : one-cycle stop request for the next spinning reel
//   reel_spinning   : bit k high while reel k spins
//   reel_pos        : packed reel positions, reel k at [k*SYM_W +: SYM_W]
//   busy            : high while spinning or judging
//   result_valid    : one-cycle pulse when a spin completes
//   win             : all positions equal; updated with result_valid, held otherwise
//   credits         : current balance
// Optional feature: define SLOT_AUTO_STOP_EN to add an auto-stop timeout that
// stops the next reel after AUTO_STOP_CYCLES clocks without a stop.
module slot_spin_controller
  import slot_pkg::*;
#(
  parameter int unsigned NUM_REELS        = DefNumReels,
  parameter int unsigned SYMBOLS          = DefSymbols,
  parameter int unsigned SYM_W            = DefSymW,
  parameter int unsigned STEP_CYCLES      = 1000000,
  parameter int unsigned CREDIT_W         = DefCreditW,
  parameter int unsigned INIT_CREDITS     = 10,
  parameter int unsigned WIN_PAYOUT       = 5,
  parameter int unsigned AUTO_STOP_CYCLES = 50000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_pulse,
  input  logic                       stop_pulse,
  output logic [NUM_REELS-1:0]       reel_spinning,
  output logic [NUM_REELS*SYM_W-1:0] reel_pos,
  output logic                       busy,
  output logic                       result_valid,
  output logic                       win,
  output logic [CREDIT_W-1:0]        credits
);

  localparam int unsigned IdxW = (NUM_REELS > 1) ? $clog2(NUM_REELS) : 1;

  if ((2 ** SYM_W < SYMBOLS) || (STEP_CYCLES == 0) || (AUTO_STOP_CYCLES == 0)) begin : g_cfg_err
    $error("slot_spin_controller: inconsistent parameters");
  end

  slot_state_e                state_q, state_d;
  logic [NUM_REELS-1:0]       spinning_q, spinning_d;
  logic [NUM_REELS*SYM_W-1:0] pos_q, pos_d;
  logic [IdxW-1:0]            stop_idx_q, stop_idx_d;
  logic                       result_valid_q, result_valid_d;
  logic                       win_q, win_d;
  logic [CREDIT_W-1:0]        credits_q, credits_d;

  logic              tick;
  logic              auto_stop;
  logic              start_ok;
  logic              stop_req;
  logic              last_stop;
  logic              all_equal;
  logic [CREDIT_W:0] payout_sum;

  function automatic logic [SYM_W-1:0] next_pos(input logic [SYM_W-1:0] p);
    return (p == SYM_W'(SYMBOLS - 1)) ? '0 : p + SYM_W'(1);
  endfunction

  // Prescaler only runs in SPIN, so it restarts from zero on every spin.
  spin_tick_gen #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_tick (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (state_q != StSpin),
    .tick_o (tick)
  );

`ifdef SLOT_AUTO_STOP_EN
  localparam int unsigned ToW = (AUTO_STOP_CYCLES > 1) ? $clog2(AUTO_STOP_CYCLES) : 1;

  logic [ToW-1:0] to_q, to_d;

  assign auto_stop = (state_q == StSpin) && (to_q == ToW'(AUTO_STOP_CYCLES - 1));

  // Held at zero outside SPIN, so entering SPIN starts a fresh timeout.
  always_comb begin
    if ((state_q != StSpin) || stop_req) begin
      to_d = '0;
    end else begin
      to_d = to_q + ToW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`else
  assign auto_stop = 1'b0;
`endif

  // Internal and external stop in one cycle merge into a single stop.
  assign stop_req   = (state_q == StSpin) && (stop_pulse || auto_stop);
  assign start_ok   = (state_q == StIdle) && start_pulse && (credits_q != '0);
  assign last_stop  = stop_req && (stop_idx_q == IdxW'(NUM_REELS - 1));
  assign payout_sum = {1'b0, credits_q} + (CREDIT_W + 1)'(WIN_PAYOUT);

  always_comb begin
    all_equal = 1'b1;
    for (int k = 1; k < NUM_REELS; k++) begin
      if (pos_q[k*SYM_W +: SYM_W] != pos_q[SYM_W-1:0]) begin
        all_equal = 1'b0;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      spinning_q     <= '0;
      pos_q          <= '0;
      stop_idx_q     <= '0;
      result_valid_q <= 1'b0;
      win_q          <= 1'b0;
      credits_q      <= CREDIT_W'(INIT_CREDITS);
    end else begin
      state_q        <= state_d;
      spinning_q     <= spinning_d;
      pos_q          <= pos_d;
      stop_idx_q     <= stop_idx_d;
      result_valid_q <= result_valid_d;
      win_q          <= win_d;
      credits_q      <= credits_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_ok) state_d = StSpin;
      StSpin:   if (last_stop) state_d = StResult;
      StResult: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    spinning_d     = spinning_q;
    pos_d          = pos_q;
    stop_idx_d     = stop_idx_q;
    result_valid_d = 1'b0;
    win_d          = win_q;
    credits_d      = credits_q;

    if (start_ok) begin
      spinning_d = '1;
      stop_idx_d = '0;
      credits_d  = credits_q - CREDIT_W'(1);
    end

    if (stop_req) begin
      spinning_d[stop_idx_q] = 1'b0;
      stop_idx_d             = stop_idx_q + IdxW'(1);
    end

    // Uses the post-stop mask so a reel stopped on a tick keeps its pre-tick value.
    if (tick) begin
      for (int k = 0; k < NUM_REELS; k++) begin
        if (spinning_d[k]) begin
          pos_d[k*SYM_W +: SYM_W] = next_pos(pos_q[k*SYM_W +: SYM_W]);
        end
      end
    end

    if (state_q == StResult) begin
      result_valid_d = 1'b1;
      win_d          = all_equal;
      if (all_equal) begin
        credits_d = payout_sum[CREDIT_W] ? '1 : payout_sum[CREDIT_W-1:0];
      end
    end
  end

  // Outputs.
  always_comb begin
    busy          = (state_q == StSpin) || (state_q == StResult);
    reel_spinning = spinning_q;
    reel_pos      = pos_q;
    result_valid  = result_valid_q;
    win           = win_q;
    credits       = credits_q;
  end

endmodule

// File: tb/tb_slot_spin_controller.sv
// Self-checking bench for slot_spin_controller. Expected values come from a
// closed-form model: a reel stopped at spin index s shows base + floor(s/STEP).
module tb_slot_spin_controller;

  localparam int unsigned NR   = 3;
  localparam int unsigned SYMS = 8;
  localparam int unsigned SW   = 3;
  localparam int unsigned STEP = 4;
  localparam int unsigned CW   = 8;
  localparam int unsigned INIT = 2;
  localparam int unsigned PAY  = 5;
  localparam int unsigned AUTO = 64;
  localparam int          CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_pulse;
  logic              stop_pulse;
  logic [NR-1:0]     reel_spinning;
  logic [NR*SW-1:0]  reel_pos;
  logic              busy;
  logic              result_valid;
  logic              win;
  logic [CW-1:0]     credits;

  int n_cmp = 0;
  int n_err = 0;

  int model_credits;
  int model_pos[NR];
  bit model_win;

  slot_spin_controller #(
    .NUM_REELS        (NR),
    .SYMBOLS          (SYMS),
    .SYM_W            (SW),
    .STEP_CYCLES      (STEP),
    .CREDIT_W         (CW),
    .INIT_CREDITS     (INIT),
    .WIN_PAYOUT       (PAY),
    .AUTO_STOP_CYCLES (AUTO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_pulse   (start_pulse),
    .stop_pulse    (stop_pulse),
    .reel_spinning (reel_spinning),
    .reel_pos      (reel_pos),
    .busy          (busy),
    .result_valid  (result_valid),
    .win           (win),
    .credits       (credits)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_credits = INIT;
    model_win     = 1'b0;
    for (int k = 0; k < NR; k++) model_pos[k] = 0;
  endtask

  task automatic test_reset();
    start_pulse = 1'b0;
    stop_pulse  = 1'b0;
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      n_cmp += 5;
      if (credits !== CW'(INIT)) begin
        n_err++; $display("FAIL reset_credits c=%0d got %0d want %0d", c, credits, INIT);
      end
      if (reel_pos !== '0) begin
        n_err++; $display("FAIL reset_pos c=%0d got %h want 0", c, reel_pos);
      end
      if (busy !== 1'b0) begin
        n_err++; $display("FAIL reset_busy c=%0d got %b want 0", c, busy);
      end
      if (reel_spinning !== '0) begin
        n_err++; $display("FAIL reset_spinning c=%0d got %b want 0", c, reel_spinning);
      end
      if (result_valid !== 1'b0) begin
        n_err++; $display("FAIL reset_result_valid c=%0d got %b want 0", c, result_valid);
      end
      step();
    end
  endtask

  // One full spin; s0 < s1 < s2 are spin indices (0 = first cycle after acceptance)
  // at which each reel's stop is issued. Ends on the result_valid cycle.
  task automatic run_spin(input int s0, input int s1, input int s2, input bit drive_stops,
                          input bit poke_start, input bit stop_with_start, input string tag);
    int               s[NR];
    int               base[NR];
    int               fin[NR];
    int               p;
    int               cred_run;
    int               cred_end;
    bit               exp_win;
    logic [NR-1:0]    exp_spin;
    logic [NR*SW-1:0] exp_pos;
    s    = '{s0, s1, s2};
    base = model_pos;
    for (int k = 0; k < NR; k++) fin[k] = (base[k] + s[k] / STEP) % SYMS;
    exp_win = 1'b1;
    for (int k = 1; k < NR; k++) if (fin[k] != fin[0]) exp_win = 1'b0;
    cred_run = model_credits - 1;
    cred_end = exp_win ? ((cred_run + PAY > CMAX) ? CMAX : cred_run + PAY) : cred_run;

    start_pulse = 1'b1;
    stop_pulse  = stop_with_start;
    step();
    start_pulse = 1'b0;
    stop_pulse  = 1'b0;

    for (int i = 0; i <= s[NR-1] + 2; i++) begin
      for (int k = 0; k < NR; k++) begin
        p = (base[k] + ((i < s[k]) ? i : s[k]) / STEP) % SYMS;
        exp_pos[k*SW +: SW] = SW'(p);
        exp_spin[k]         = (i <= s[k]);
      end
      n_cmp += 5;
      if (reel_pos !== exp_pos) begin
        n_err++; $display("FAIL %s pos i=%0d got %h want %h", tag, i, reel_pos, exp_pos);
      end
      if (reel_spinning !== exp_spin) begin
        n_err++; $display("FAIL %s spinning i=%0d got %b want %b", tag, i, reel_spinning, exp_spin);
      end
      if (busy !== (i <= s[NR-1] + 1)) begin
        n_err++; $display("FAIL %s busy i=%0d got %b want %b", tag, i, busy, (i <= s[NR-1] + 1));
      end
      if (result_valid !== (i == s[NR-1] + 2)) begin
        n_err++; $display("FAIL %s result_valid i=%0d got %b want %b", tag, i, result_valid,
                          (i == s[NR-1] + 2));
      end
      if (i == s[NR-1] + 2) begin
        n_cmp++;
        if (win !== exp_win) begin
          n_err++; $display("FAIL %s win got %b want %b", tag, win, exp_win);
        end
        if (credits !== CW'(cred_end)) begin
          n_err++; $display("FAIL %s credits_end got %0d want %0d", tag, credits, cred_end);
        end
        break;
      end
      if (win !== model_win) begin
        n_err++; $display("FAIL %s win_hold i=%0d got %b want %b", tag, i, win, model_win);
      end
      n_cmp++;
      if (credits !== CW'(cred_run)) begin
        n_err++; $display("FAIL %s credits_run i=%0d got %0d want %0d", tag, i, credits, cred_run);
      end
      stop_pulse  = drive_stops && (i == s[0] || i == s[1] || i == s[2]);
      start_pulse = poke_start && (($urandom_range(0, 3) == 0) || (i == s[NR-1] + 1));
      step();
      stop_pulse  = 1'b0;
      start_pulse = 1'b0;
    end
    model_pos     = fin;
    model_credits = cred_end;
    model_win     = exp_win;
  endtask

  task automatic test_random();
    int a;
    int b;
    int c;
    for (int n = 0; n < 12; n++) begin
      if (model_credits == 0) apply_reset();
      a = $urandom_range(0, 40);
      b = a + $urandom_range(1, 40);
      c = b + $urandom_range(1, 40);
      run_spin(a, b, c, 1'b1, 1'b1, 1'b0, "random");
    end
  endtask

  task automatic test_drain_and_idle();
    logic [NR*SW-1:0] exp_pos;
    int it;
    it = 0;
    while (model_credits > 0 && it < 400) begin
      run_spin(0, 4, 8, 1'b1, 1'b0, 1'b0, "drain");
      it++;
    end
    n_cmp++;
    if (model_credits != 0) begin
      n_err++; $display("FAIL drain_bound got %0d want 0", model_credits);
    end
    step();
    for (int k = 0; k < NR; k++) exp_pos[k*SW +: SW] = SW'(model_pos[k]);
    start_pulse = 1'b1;
    step();
    start_pulse = 1'b0;
    n_cmp += 3;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL zero_credit_start busy got %b want 0", busy);
    end
    if (reel_spinning !== '0) begin
      n_err++; $display("FAIL zero_credit_start spinning got %b want 0", reel_spinning);
    end
    if (credits !== '0) begin
      n_err++; $display("FAIL zero_credit_start credits got %0d want 0", credits);
    end
    stop_pulse = 1'b1;
    step();
    stop_pulse = 1'b0;
    step();
    n_cmp += 2;
    if (reel_pos !== exp_pos) begin
      n_err++; $display("FAIL idle_stop pos got %h want %h", reel_pos, exp_pos);
    end
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL idle_stop busy got %b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_spin();
    apply_reset();
    start_pulse = 1'b1;
    step();
    start_pulse = 1'b0;
    for (int c = 0; c < 6; c++) step();
    stop_pulse = 1'b1;
    step();
    stop_pulse = 1'b0;
    step();
    n_cmp++;
    if (reel_spinning !== 3'b110) begin
      n_err++; $display("FAIL midspin_pre spinning got %b want 110", reel_spinning);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp += 6;
    if (credits !== CW'(INIT)) begin
      n_err++; $display("FAIL midspin_rst credits got %0d want %0d", credits, INIT);
    end
    if (reel_pos !== '0) begin
      n_err++; $display("FAIL midspin_rst pos got %h want 0", reel_pos);
    end
    if (reel_spinning !== '0) begin
      n_err++; $display("FAIL midspin_rst spinning got %b want 0", reel_spinning);
    end
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL midspin_rst busy got %b want 0", busy);
    end
    if (result_valid !== 1'b0) begin
      n_err++; $display("FAIL midspin_rst result_valid got %b want 0", result_valid);
    end
    if (win !== 1'b0) begin
      n_err++; $display("FAIL midspin_rst win got %b want 0", win);
    end
    for (int c = 0; c < 10; c++) begin
      step();
      n_cmp++;
      if (result_valid !== 1'b0 || credits !== CW'(INIT)) begin
        n_err++; $display("FAIL midspin_after c=%0d got rv=%b cr=%0d want rv=0 cr=%0d", c,
                          result_valid, credits, INIT);
      end
    end
    model_credits = INIT;
    model_win     = 1'b0;
    for (int k = 0; k < NR; k++) model_pos[k] = 0;
  endtask

  task automatic test_saturation();
    int r;
    int hits;
    apply_reset();
    hits = 0;
    for (int it = 0; it < 80 && hits < 2; it++) begin
      r = $urandom_range(0, 3);
      run_spin(r, r + 32, r + 64, 1'b1, 1'b0, 1'b0, "saturate");
      if (model_credits == CMAX) hits++;
    end
    n_cmp++;
    if (credits !== CW'(CMAX) || hits < 2) begin
      n_err++; $display("FAIL saturation got %0d hits=%0d want %0d hits=2", credits, hits, CMAX);
    end
  endtask

  initial begin
    rst         = 1'b1;
    start_pulse = 1'b0;
    stop_pulse  = 1'b0;
    test_reset();
    run_spin(2, 34, 66, 1'b1, 1'b0, 1'b0, "wrap_win");
    run_spin(1, 5, 9, 1'b1, 1'b0, 1'b0, "lose");
    run_spin(3, 7, 11, 1'b1, 1'b0, 1'b0, "stop_on_tick");
    run_spin(5, 9, 20, 1'b1, 1'b1, 1'b1, "start_stop_same_cycle");
    test_random();
    if (model_credits == 0) apply_reset();
`ifdef SLOT_AUTO_STOP_EN
    run_spin(AUTO - 1, 2 * AUTO - 1, 3 * AUTO - 1, 1'b0, 1'b0, 1'b0, "auto_stop");
`else
    run_spin(1000, 1001, 1002, 1'b1, 1'b0, 1'b0, "no_auto_stop");
`endif
    test_drain_and_idle();
    test_reset_mid_spin();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
